// File: rtl/bc_pkg.sv
// Shared types and constants for the barcode station-ID reader.
package bc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MEAS,
      WAIT_FALL,
      DELAY,
      FINISH
   } bc_state_t;

   // Number of data bits in one frame, shifted in MSB first.
   localparam int unsigned NBITS = 8;

   // Station IDs are only accepted when their two MSBs carry this prefix.
   localparam logic [1:0] ID_PREFIX = 2'b00;

endpackage

// File: rtl/bc_sync_edge.sv
// Two-flop synchronizer for the raw barcode line plus one flop for edge detection.
// All flops reset to 1 so an idle (high) line produces no spurious edge after reset.
import bc_pkg::*;

module bc_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic fall,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchronizer chain followed by the delayed copy used for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_out = sync_q;
   assign fall     = prev_q & ~sync_q;
   assign rise     = ~prev_q & sync_q;

endmodule

// File: rtl/bc_reader.sv
// Barcode station-ID decoder: measures the start-bit width T, samples each data bit
// floor(T/2) cycles after its falling edge, and publishes prefix-checked IDs with a
// sticky valid flag that the station FSM clears once it has consumed the ID.
import bc_pkg::*;

module bc_reader #(
   parameter int unsigned TW      = 22,
   parameter int unsigned TIMEOUT = 2_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       BC,
   input  logic       clr_ID_vld,
   output logic [7:0] ID,
   output logic       ID_vld,
   output logic       busy
);

   localparam int unsigned CW  = $clog2(NBITS + 1);
   localparam logic [TW-1:0] PMAX = '1;
   localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);
   localparam logic [TW-1:0] ONE  = TW'(1);

   logic sync;
   logic fall;
   logic rise;

   bc_state_t        state_q,   state_d;
   logic [TW-1:0]    period_q,  period_d;
   logic [TW-1:0]    t_len_q,   t_len_d;
   logic [TW-1:0]    idle_q,    idle_d;
   logic [TW-1:0]    delay_q,   delay_d;
   logic [NBITS-1:0] shift_q,   shift_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]       id_q,      id_d;
   logic             vld_q,     vld_d;

   bc_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (BC),
      .sync_out (sync),
      .fall     (fall),
      .rise     (rise)
   );

   // Next-state logic for the frame FSM, timers, shift register and ID register.
   always_comb begin
      state_d   = state_q;
      period_d  = period_q;
      t_len_d   = t_len_q;
      idle_d    = idle_q;
      delay_d   = delay_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      id_d      = id_q;
      vld_d     = vld_q;

      // Clear first so a set in FINISH below takes priority.
      if (clr_ID_vld) begin
         vld_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (fall) begin
               period_d = '0;
               state_d  = MEAS;
            end
         end
         MEAS: begin
            if (rise) begin
               t_len_d   = period_q;
               bit_cnt_d = '0;
               idle_d    = '0;
               state_d   = WAIT_FALL;
            end else if (period_q == PMAX) begin
               // Start bit too long to be a real frame.
               state_d = IDLE;
            end else if (!sync) begin
               period_d = period_q + ONE;
            end
         end
         WAIT_FALL: begin
            if (fall) begin
               delay_d = t_len_q >> 1;
               state_d = DELAY;
            end else if (idle_q == TMO) begin
               // Line stalled mid-frame: drop the partial bits.
               state_d = IDLE;
            end else begin
               idle_d = idle_q + ONE;
            end
         end
         DELAY: begin
            if (delay_q == '0) begin
               shift_d   = {shift_q[NBITS-2:0], sync};
               bit_cnt_d = bit_cnt_q + CW'(1);
               idle_d    = '0;
               state_d   = (bit_cnt_q == CW'(NBITS - 1)) ? FINISH : WAIT_FALL;
            end else begin
               delay_d = delay_q - ONE;
            end
         end
         FINISH: begin
            if (shift_q[NBITS-1 -: 2] == ID_PREFIX) begin
               id_d  = shift_q;
               vld_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         period_q  <= '0;
         t_len_q   <= '0;
         idle_q    <= '0;
         delay_q   <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         id_q      <= 8'h00;
         vld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         t_len_q   <= t_len_d;
         idle_q    <= idle_d;
         delay_q   <= delay_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         id_q      <= id_d;
         vld_q     <= vld_d;
      end
   end

   assign ID     = id_q;
   assign ID_vld = vld_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bc_reader.sv
// Self-checking bench for bc_reader: table of complete frames plus hand-written
// sequences for timeout, saturation, clear/set race, back-to-back and reset cases.
module tb_bc_reader;

   localparam int unsigned TW      = 12;
   localparam int unsigned TIMEOUT = 2000;

   // Short-frame timing used by most sequences: T = 199, sample 99 cycles after fall.
   localparam int LS = 200;
   localparam int L0 = 200;
   localparam int L1 = 50;
   localparam int PER = 300;

   logic       clk = 1'b0;
   logic       rst;
   logic       BC;
   logic       clr_ID_vld;
   logic [7:0] ID;
   logic       ID_vld;
   logic       busy;

   int checks = 0;
   int errors = 0;
   bit vld_drop;

   typedef struct {
      logic [7:0] id;
      logic       vld;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      int         lstart;
      int         low0;
      int         low1;
      int         per;
      logic [7:0] exp_id;
      logic       exp_vld;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];

   bc_reader #(
      .TW      (TW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .BC         (BC),
      .clr_ID_vld (clr_ID_vld),
      .ID         (ID),
      .ID_vld     (ID_vld),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic expect_frame(input logic [7:0] id, input logic vld);
      exp_t e;
      e.id  = id;
      e.vld = vld;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One bit cell: low for 'low' cycles then high to the end of 'per'.
   // mode 1: check ID_vld latency, 2: clr_ID_vld in FINISH cycle, 3: monitor ID_vld.
   task automatic send_bit(input int low, input int per, input int thalf, input int mode);
      for (int c = 0; c < per; c++) begin
         BC = (c < low) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
         if (mode == 3 && !ID_vld) vld_drop = 1'b1;
         if (mode == 1 && c + 1 == thalf + 4) check("vld_before_finish", ID_vld, 0);
         if (mode == 1 && c + 1 == thalf + 5) begin
            check("vld_rise_latency", ID_vld, 1);
            check("id_at_rise", ID, 8'h15);
         end
         if (mode == 2 && c + 1 == thalf + 4) clr_ID_vld = 1'b1;
         if (mode == 2 && c + 1 == thalf + 5) begin
            clr_ID_vld = 1'b0;
            check("race_vld", ID_vld, 1);
            check("race_id", ID, 8'h07);
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input int lstart, input int low0,
                             input int low1, input int per, input int nbits, input int mode);
      int thalf;
      thalf = (lstart - 1) / 2;
      send_bit(lstart, per, thalf, (mode == 3) ? 3 : 0);
      for (int i = 0; i < nbits; i++) begin
         send_bit(data[7-i] ? low1 : low0, per, thalf,
                  (i == nbits - 1 || mode == 3) ? mode : 0);
      end
   endtask

   // Wait (bounded) for the FSM to go idle, then pop and compare the expectation.
   task automatic finish_frame(input string name);
      exp_t e;
      bit   done;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         if (!busy) done = 1'b1;
         else tick(1);
      end
      check({name, "_idle"}, done, 1);
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s_sb: got empty scoreboard, expected one entry", name);
      end else begin
         e = sb.pop_front();
         check({name, "_id"}, ID, e.id);
         check({name, "_vld"}, ID_vld, e.vld);
      end
   endtask

   initial begin
      vecs[0] = '{8'h15, 1000, 1000, 250, 1500, 8'h15, 1'b1};
      vecs[1] = '{8'hC5, LS, L0, L1, PER, 8'h15, 1'b1};
      vecs[2] = '{8'h00, LS, L0, L1, PER, 8'h00, 1'b1};
      vecs[3] = '{8'h80, LS, L0, L1, PER, 8'h00, 1'b1};
      vecs[4] = '{8'h40, LS, L0, L1, PER, 8'h00, 1'b1};
      vecs[5] = '{8'h3F, LS, L0, L1, PER, 8'h3F, 1'b1};

      rst        = 1'b1;
      BC         = 1'b1;
      clr_ID_vld = 1'b0;
      vld_drop   = 1'b0;
      tick(3);
      check("reset_id", ID, 8'h00);
      check("reset_vld", ID_vld, 0);
      check("reset_busy", busy, 0);
      rst = 1'b0;
      tick(5);

      // Table-driven complete frames; the first one also checks output latency.
      for (int i = 0; i < 6; i++) begin
         expect_frame(vecs[i].exp_id, vecs[i].exp_vld);
         send_frame(vecs[i].data, vecs[i].lstart, vecs[i].low0, vecs[i].low1,
                    vecs[i].per, 8, (i == 0) ? 1 : 0);
         finish_frame($sformatf("vec%0d", i));
      end

      // Lone clear drops ID_vld on the next cycle and leaves ID alone.
      clr_ID_vld = 1'b1;
      tick(1);
      clr_ID_vld = 1'b0;
      check("clr_vld", ID_vld, 0);
      check("clr_keeps_id", ID, 8'h3F);

      // Timeout: start bit plus three data bits, then the line stays high.
      send_frame(8'h2A, LS, L0, L1, PER, 3, 0);
      tick(TIMEOUT - 199);
      check("tmo_still_busy", busy, 1);
      tick(5);
      check("tmo_idle", busy, 0);
      check("tmo_vld", ID_vld, 0);
      check("tmo_id", ID, 8'h3F);

      expect_frame(8'h2A, 1'b1);
      send_frame(8'h2A, LS, L0, L1, PER, 8, 0);
      finish_frame("after_tmo");

      // Set in FINISH wins over a simultaneous clear.
      expect_frame(8'h07, 1'b1);
      send_frame(8'h07, LS, L0, L1, PER, 8, 2);
      finish_frame("race");

      clr_ID_vld = 1'b1;
      tick(1);
      clr_ID_vld = 1'b0;
      check("race_clr_vld", ID_vld, 0);
      clr_ID_vld = 1'b1;
      tick(1);
      clr_ID_vld = 1'b0;
      check("clr_when_low_vld", ID_vld, 0);
      check("clr_when_low_id", ID, 8'h07);

      // Back-to-back valid frames without a clear: ID_vld must never drop.
      expect_frame(8'h01, 1'b1);
      send_frame(8'h01, LS, L0, L1, PER, 8, 0);
      finish_frame("b2b_first");
      expect_frame(8'h3F, 1'b1);
      send_frame(8'h3F, LS, L0, L1, PER, 8, 3);
      finish_frame("b2b_second");
      check("b2b_vld_held", vld_drop, 0);

      // Start bit longer than the period timer can count aborts silently.
      BC = 1'b0;
      tick(100);
      check("sat_busy", busy, 1);
      tick(4200);
      check("sat_idle", busy, 0);
      check("sat_id", ID, 8'h3F);
      check("sat_vld", ID_vld, 1);
      BC = 1'b1;
      tick(20);

      // Reset during bit 4 clears outputs without waiting for a clock edge.
      send_frame(8'h12, LS, L0, L1, PER, 3, 0);
      BC = 1'b0;
      tick(50);
      check("rst_mid_busy_before", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_id", ID, 8'h00);
      check("rst_async_vld", ID_vld, 0);
      check("rst_async_busy", busy, 0);
      BC = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(10);

      expect_frame(8'h12, 1'b1);
      send_frame(8'h12, LS, L0, L1, PER, 8, 0);
      finish_frame("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
